// File: rtl/hex_display_pkg.sv
// Shared constants and glyph lookup for the multiplexed hex display.
package hex_display_pkg;

    // All segments dark on an active-low bus.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low segment pattern for one hex nibble.
    function automatic logic [6:0] digit_glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational nibble to active-low 7-segment pattern lookup.
import hex_display_pkg::*;

module hex_glyph_rom (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Pure table lookup; no state.
    always_comb begin
        seg_n = digit_glyph(nibble);
    end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS digits onto one
// shared active-low segment bus, with frame-synchronous loading,
// leading-zero blanking, per-digit decimal points and per-digit blinking.
import hex_display_pkg::*;

module hex_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    // Scan timing state
    logic [PW-1:0] prescale_r;
    logic [IW-1:0] idx_r;
    logic [FW-1:0] frame_cnt_r;
    logic          blink_r;

    // Shown and shadow copies of the loadable inputs
    logic [4*NUM_DIGITS-1:0] disp_val_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic [NUM_DIGITS-1:0]   disp_blink_r;
    logic [4*NUM_DIGITS-1:0] pend_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic [NUM_DIGITS-1:0]   pend_blink_r;
    logic                    pend_flag_r;

    // Output registers
    logic [6:0]            seg_n_r;
    logic                  dp_n_r;
    logic [NUM_DIGITS-1:0] an_n_r;

    // Combinational helpers
    logic                  tc_s;
    logic                  frame_s;
    logic [3:0]            nib_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero_s;
    logic [3:0]            cur_nib_s;
    logic                  cur_dp_s;
    logic                  lz_off_s;
    logic                  blink_off_s;
    logic [6:0]            glyph_s;
    logic [6:0]            seg_next_s;
    logic                  dp_next_s;
    logic [NUM_DIGITS-1:0] an_next_s;

    // Terminal count of the per-digit prescaler and the frame boundary.
    always_comb begin
        tc_s    = (prescale_r == PRE_LAST);
        frame_s = tc_s && (idx_r == IDX_LAST);
    end

    // Prescaler and digit index; both free-run regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r <= PW'(0);
            idx_r      <= IW'(0);
        end else if (tc_s) begin
            prescale_r <= PW'(0);
            idx_r      <= (idx_r == IDX_LAST) ? IW'(0) : idx_r + IW'(1);
        end else begin
            prescale_r <= prescale_r + PW'(1);
            idx_r      <= idx_r;
        end
    end

    // Frame counter and blink phase advance once per complete scan frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= FW'(0);
            blink_r     <= 1'b0;
        end else if (frame_s) begin
            if (frame_cnt_r == FRM_LAST) begin
                frame_cnt_r <= FW'(0);
                blink_r     <= ~blink_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FW'(1);
                blink_r     <= blink_r;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
            blink_r     <= blink_r;
        end
    end

    // Load shadowing: display registers only change on a frame boundary,
    // so a frame never shows a mix of old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            disp_blink_r <= {NUM_DIGITS{1'b0}};
            pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blink_r <= {NUM_DIGITS{1'b0}};
            pend_flag_r  <= 1'b0;
        end else if (frame_s) begin
            // A load on the boundary itself bypasses the shadow copy.
            if (load) begin
                disp_val_r   <= value;
                disp_dp_r    <= dp_in;
                disp_blink_r <= blink_mask;
            end else if (pend_flag_r) begin
                disp_val_r   <= pend_val_r;
                disp_dp_r    <= pend_dp_r;
                disp_blink_r <= pend_blink_r;
            end else begin
                disp_val_r   <= disp_val_r;
                disp_dp_r    <= disp_dp_r;
                disp_blink_r <= disp_blink_r;
            end
            pend_flag_r <= 1'b0;
        end else if (load) begin
            // Last load before the boundary wins.
            pend_val_r   <= value;
            pend_dp_r    <= dp_in;
            pend_blink_r <= blink_mask;
            pend_flag_r  <= 1'b1;
        end else begin
            pend_flag_r <= pend_flag_r;
        end
    end

    // Split the shown value into nibbles and flag digits whose own nibble
    // and every more significant nibble are zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib_s[i]        = disp_val_r[4*i +: 4];
            upper_zero_s[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                upper_zero_s[i] = upper_zero_s[i] & (disp_val_r[4*j +: 4] == 4'h0);
            end
        end
    end

    // Select the digit currently being scanned and its blanking reasons.
    always_comb begin
        cur_nib_s   = nib_s[idx_r];
        cur_dp_s    = disp_dp_r[idx_r];
        lz_off_s    = lz_blank && (idx_r != IW'(0)) && upper_zero_s[idx_r];
        blink_off_s = blink_r && disp_blink_r[idx_r];
    end

    hex_glyph_rom u_glyph_rom (
        .nibble (cur_nib_s),
        .seg_n  (glyph_s)
    );

    // Next output values; leading-zero blanking keeps dp, blinking does not.
    always_comb begin
        seg_next_s = SEG_BLANK;
        dp_next_s  = 1'b1;
        an_next_s  = {NUM_DIGITS{1'b1}};
        if (en) begin
            an_next_s = ~(NUM_DIGITS'(1) << idx_r);
            if (lz_off_s || blink_off_s) begin
                seg_next_s = SEG_BLANK;
            end else begin
                seg_next_s = glyph_s;
            end
            if (blink_off_s) begin
                dp_next_s = 1'b1;
            end else begin
                dp_next_s = ~cur_dp_s;
            end
        end else begin
            seg_next_s = SEG_BLANK;
            dp_next_s  = 1'b1;
            an_next_s  = {NUM_DIGITS{1'b1}};
        end
    end

    // Register all pin outputs together so anode and segments switch in
    // the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n_r <= SEG_BLANK;
            dp_n_r  <= 1'b1;
            an_n_r  <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_n_r <= seg_next_s;
            dp_n_r  <= dp_next_s;
            an_n_r  <= an_next_s;
        end
    end

    assign seg_n = seg_n_r;
    assign dp_n  = dp_n_r;
    assign an_n  = an_n_r;

endmodule
